// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB slave port.
// One transfer in flight; an ACCESS-phase watchdog completes stuck transfers with an error.
module apb_req_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_m0_req,
    input  logic          i_m0_write,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rsp,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_write,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rsp,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_psel,
    output logic          o_penable,
    output logic          o_pwrite,
    output logic [AW-1:0] o_paddr,
    output logic [DW-1:0] o_pwdata,
    input  logic [DW-1:0] i_prdata,
    input  logic          i_pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t        state_r, state_s;
    logic          last_r, last_s;
    logic          id_r, id_s;
    logic [7:0]    wd_r, wd_s;
    logic          win_s;
    logic          psel_s, penable_s, pwrite_s;
    logic [AW-1:0] paddr_s;
    logic [DW-1:0] pwdata_s;
    logic          m0_gnt_s, m1_gnt_s, m0_rsp_s, m1_rsp_s, m0_err_s, m1_err_s;
    logic [DW-1:0] m0_rdata_s, m1_rdata_s, done_rdata_s;

    // Next-state and next-output computation; every output is the registered copy of these.
    always_comb begin
        state_s      = state_r;
        last_s       = last_r;
        id_s         = id_r;
        wd_s         = wd_r;
        psel_s       = 1'b0;
        penable_s    = 1'b0;
        pwrite_s     = o_pwrite;
        paddr_s      = o_paddr;
        pwdata_s     = o_pwdata;
        m0_gnt_s     = 1'b0;
        m1_gnt_s     = 1'b0;
        m0_rsp_s     = 1'b0;
        m1_rsp_s     = 1'b0;
        m0_err_s     = o_m0_err;
        m1_err_s     = o_m1_err;
        m0_rdata_s   = o_m0_rdata;
        m1_rdata_s   = o_m1_rdata;
        done_rdata_s = {DW{1'b0}};
        // A lone requester always wins; on a tie the one not granted last wins.
        if (i_m0_req && i_m1_req) begin
            win_s = ~last_r;
        end else begin
            win_s = i_m1_req;
        end

        case (state_r)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    id_s     = win_s;
                    last_s   = win_s;
                    pwrite_s = win_s ? i_m1_write : i_m0_write;
                    paddr_s  = win_s ? i_m1_addr  : i_m0_addr;
                    pwdata_s = win_s ? i_m1_wdata : i_m0_wdata;
                    m0_gnt_s = ~win_s;
                    m1_gnt_s = win_s;
                    psel_s   = 1'b1;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                wd_s      = 8'd0;
                psel_s    = 1'b1;
                penable_s = 1'b1;
                state_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (i_pready || (wd_r == WD_LAST)) begin
                    if (i_pready && !o_pwrite) begin
                        done_rdata_s = i_prdata;
                    end else begin
                        done_rdata_s = {DW{1'b0}};
                    end
                    if (id_r) begin
                        m1_rsp_s   = 1'b1;
                        m1_err_s   = ~i_pready;
                        m1_rdata_s = done_rdata_s;
                    end else begin
                        m0_rsp_s   = 1'b1;
                        m0_err_s   = ~i_pready;
                        m0_rdata_s = done_rdata_s;
                    end
                    state_s = ST_IDLE;
                end else begin
                    wd_s      = wd_r + 8'd1;
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                    state_s   = ST_ACCESS;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer, watchdog and all output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            id_r       <= 1'b0;
            wd_r       <= 8'd0;
            o_psel     <= 1'b0;
            o_penable  <= 1'b0;
            o_pwrite   <= 1'b0;
            o_paddr    <= {AW{1'b0}};
            o_pwdata   <= {DW{1'b0}};
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_rsp   <= 1'b0;
            o_m1_rsp   <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m0_rdata <= {DW{1'b0}};
            o_m1_rdata <= {DW{1'b0}};
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            id_r       <= id_s;
            wd_r       <= wd_s;
            o_psel     <= psel_s;
            o_penable  <= penable_s;
            o_pwrite   <= pwrite_s;
            o_paddr    <= paddr_s;
            o_pwdata   <= pwdata_s;
            o_m0_gnt   <= m0_gnt_s;
            o_m1_gnt   <= m1_gnt_s;
            o_m0_rsp   <= m0_rsp_s;
            o_m1_rsp   <= m1_rsp_s;
            o_m0_err   <= m0_err_s;
            o_m1_err   <= m1_err_s;
            o_m0_rdata <= m0_rdata_s;
            o_m1_rdata <= m1_rdata_s;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: directed transfers, expected transactions queued in grant order.
module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_m0_req, i_m0_write, i_m1_req, i_m1_write;
    logic [11:0] i_m0_addr, i_m1_addr, o_paddr;
    logic [31:0] i_m0_wdata, i_m1_wdata, o_m0_rdata, o_m1_rdata, o_pwdata, i_prdata;
    logic        o_m0_gnt, o_m0_rsp, o_m0_err, o_m1_gnt, o_m1_rsp, o_m1_err;
    logic        o_psel, o_penable, o_pwrite, i_pready;

    typedef struct {
        logic        id;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          wait_n;
        logic        err;
        logic [31:0] rdata;
        int          acc;
        bit          b2b;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   in_flight = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   prev_gnt = 0;
    int   acc = 0;
    int   sacc = 0;

    apb_req_arbiter #(.AW(12), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_req(i_m0_req), .i_m0_write(i_m0_write), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .o_m0_gnt(o_m0_gnt), .o_m0_rsp(o_m0_rsp), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_write(i_m1_write), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .o_m1_gnt(o_m1_gnt), .o_m1_rsp(o_m1_rsp), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite), .o_paddr(o_paddr),
        .o_pwdata(o_pwdata), .i_prdata(i_prdata), .i_pready(i_pready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic txn_t mk(input logic id, input logic wr, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [31:0] prdata, input int wait_n,
                                input logic err, input logic [31:0] rdata, input int acc_n, input bit b2b);
        txn_t t;
        t.id = id; t.wr = wr; t.addr = addr; t.wdata = wdata; t.prdata = prdata;
        t.wait_n = wait_n; t.err = err; t.rdata = rdata; t.acc = acc_n; t.b2b = b2b;
        return t;
    endfunction

    // Requester model: present a request, hold it until gnt, optionally drop it.
    task automatic issue(input logic id, input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input bit drop);
        int n = 0;
        if (id) begin
            i_m1_req = 1'b1; i_m1_write = wr; i_m1_addr = a; i_m1_wdata = d;
        end else begin
            i_m0_req = 1'b1; i_m0_write = wr; i_m0_addr = a; i_m0_wdata = d;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? o_m1_gnt : o_m0_gnt) && n < 200);
        chk(id ? "m1_gnt_seen" : "m0_gnt_seen", {31'd0, (id ? o_m1_gnt : o_m0_gnt)}, 32'd1);
        if (drop) begin
            if (id) i_m1_req = 1'b0;
            else    i_m0_req = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'd0, (exp_q.size() == 0 && !in_flight)}, 32'd1);
    endtask

    // APB slave: holds pready low for wait_n ACCESS cycles of the current transfer.
    initial begin
        i_pready = 1'b0;
        i_prdata = 32'd0;
        forever begin
            @(negedge clk);
            if (o_psel && o_penable) begin
                sacc++;
                i_pready = (sacc > cur.wait_n);
                i_prdata = cur.prdata;
            end else begin
                sacc = 0;
                i_pready = 1'b0;
                i_prdata = 32'd0;
            end
        end
    end

    // Monitor: pops the expected transaction at each gnt and checks phases, fields and the response.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                in_flight = 1'b0;
            end else begin
                if (o_m0_gnt && o_m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
                if (o_m0_rsp && o_m1_rsp) chk("dual_rsp", 32'd1, 32'd0);
                if (o_m0_gnt || o_m1_gnt) begin
                    chk("gnt_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("gnt_id", {31'd0, o_m1_gnt}, {31'd0, cur.id});
                        chk("setup_phase", {30'd0, o_psel, o_penable}, 32'd2);
                        if (cur.b2b) chk("gnt_interval", cycle - prev_gnt, 32'd3);
                        prev_gnt = cycle;
                        in_flight = 1'b1;
                        acc = 0;
                    end
                end
                if (o_psel && o_penable && in_flight) begin
                    acc++;
                    chk("paddr", {20'd0, o_paddr}, {20'd0, cur.addr});
                    chk("pwrite", {31'd0, o_pwrite}, {31'd0, cur.wr});
                    chk("pwdata", o_pwdata, cur.wdata);
                end
                if (o_m0_rsp || o_m1_rsp) begin
                    chk("rsp_expected", {31'd0, in_flight}, 32'd1);
                    if (in_flight) begin
                        chk("rsp_id", {31'd0, o_m1_rsp}, {31'd0, cur.id});
                        chk("rsp_err", {31'd0, (cur.id ? o_m1_err : o_m0_err)}, {31'd0, cur.err});
                        chk("rsp_rdata", cur.id ? o_m1_rdata : o_m0_rdata, cur.rdata);
                        chk("access_cycles", acc, cur.acc);
                        chk("idle_after_rsp", {30'd0, o_psel, o_penable}, 32'd0);
                        in_flight = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        i_m0_req = 1'b0; i_m0_write = 1'b0; i_m0_addr = 12'd0; i_m0_wdata = 32'd0;
        i_m1_req = 1'b0; i_m1_write = 1'b0; i_m1_addr = 12'd0; i_m1_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {24'd0, o_psel, o_penable, o_pwrite, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp,
            o_m0_err | o_m1_err}, 32'd0);
        chk("reset_paddr", {20'd0, o_paddr}, 32'd0);
        chk("reset_rdata", o_m0_rdata | o_m1_rdata | o_pwdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single m0 write, zero wait states
        exp_q.push_back(mk(1'b0, 1'b1, 12'h010, 32'h3, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 1, 1'b0));
        issue(1'b0, 1'b1, 12'h010, 32'h3, 1'b1);
        drain();

        // 2: m1 read with 4 wait states; rdata must then hold
        exp_q.push_back(mk(1'b1, 1'b0, 12'h020, 32'h0, 32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF, 5, 1'b0));
        issue(1'b1, 1'b0, 12'h020, 32'h0, 1'b1);
        drain();
        repeat (4) @(negedge clk);
        chk("m1_rdata_hold", o_m1_rdata, 32'hDEAD_BEEF);
        chk("m1_err_hold", {31'd0, o_m1_err}, 32'd0);

        // 3: both requesting continuously, alternating grants
        exp_q.push_back(mk(1'b0, 1'b1, 12'h100, 32'hA0, 32'h0, 0, 1'b0, 32'h0, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h200, 32'hB0, 32'h0, 0, 1'b0, 32'h0, 1, 1'b1));
        exp_q.push_back(mk(1'b0, 1'b0, 12'h104, 32'hA1, 32'h0000_00C1, 0, 1'b0, 32'h0000_00C1, 1, 1'b1));
        exp_q.push_back(mk(1'b1, 1'b0, 12'h204, 32'hB1, 32'h0000_00D1, 0, 1'b0, 32'h0000_00D1, 1, 1'b1));
        fork
            begin
                issue(1'b0, 1'b1, 12'h100, 32'hA0, 1'b0);
                issue(1'b0, 1'b0, 12'h104, 32'hA1, 1'b1);
            end
            begin
                issue(1'b1, 1'b1, 12'h200, 32'hB0, 1'b0);
                issue(1'b1, 1'b0, 12'h204, 32'hB1, 1'b1);
            end
        join
        drain();

        // 4: m0 read times out after 8 wait cycles; pending m1 write then served normally
        exp_q.push_back(mk(1'b0, 1'b0, 12'h040, 32'h0, 32'h1234_5678, 100, 1'b1, 32'h0, 8, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h050, 32'hA5A5_5A5A, 32'h0, 0, 1'b0, 32'h0, 1, 1'b0));
        fork
            issue(1'b0, 1'b0, 12'h040, 32'h0, 1'b1);
            issue(1'b1, 1'b1, 12'h050, 32'hA5A5_5A5A, 1'b1);
        join
        drain();
        chk("m0_err_hold", {31'd0, o_m0_err}, 32'd1);

        // 5: reset during ACCESS of an m1 read aborts it silently
        exp_q.push_back(mk(1'b1, 1'b0, 12'h030, 32'h0, 32'h5555_AAAA, 100, 1'b0, 32'h0, 1, 1'b0));
        issue(1'b1, 1'b0, 12'h030, 32'h0, 1'b1);
        begin
            int n = 0;
            while (!(o_psel && o_penable) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5_access_reached", {30'd0, o_psel, o_penable}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_apb", {30'd0, o_psel, o_penable}, 32'd0);
        chk("abort_no_rsp", {30'd0, o_m0_rsp, o_m1_rsp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b1, 12'h060, 32'h11, 32'h0, 0, 1'b0, 32'h0, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 12'h070, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 2, 1'b0));
        fork
            issue(1'b0, 1'b1, 12'h060, 32'h11, 1'b1);
            issue(1'b1, 1'b0, 12'h070, 32'h0, 1'b1);
        join
        drain();

        // 6: m1 alone, back-to-back every 3 cycles
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 12'h300 + 12'(k * 4), 32'h0, 32'h100 + 32'(k), 0, 1'b0,
                               32'h100 + 32'(k), 1, (k != 0)));
        end
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b0, 12'h300 + 12'(k * 4), 32'h0, (k == 2));
        end
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
